pe_job_sched: RTL and testbench
===============================

Name: pe_job_sched

Overview:
Sequences one procEng processing element per job. Fetches a KERN_LEN-word weight window and a KERN_LEN-word data window from a shared source BRAM, streams them into the PE buffers, pulses start, waits for done, then writes the MAC result to a result memory. It sits between the layer-level controller (job queue) and the PE. It replaces hand-driven testbench sequencing of the PE write port, mem_sel and start.

Parameters:
DATA_W, 8, word width; equals data_width.
PE_AW, 4, PE buffer address width; equals PE_BUFF_ADDRS_WIDTH.
KERN_LEN, 9, words per window (weightM*weightN); must be at most 2**PE_AW.
SRC_AW, 16, source BRAM address width.
RES_AW, 16, result memory address width.
TIMEOUT, 64, maximum cycles in WAIT before error.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
job_valid  in  1  job request
job_ready  out  1  high only in IDLE
job_w_base  in  SRC_AW  weight window base in source BRAM
job_d_base  in  SRC_AW  data window base in source BRAM
job_res_addr  in  RES_AW  result destination address
job_reuse_w  in  1  skip weight load if PE weights already valid
src_rd  out  1  source read enable
src_addr  out  SRC_AW  source read address
src_rdata  in  DATA_W  source read data, valid 1 cycle after src_rd
pe_mem_wr  out  1  PE buffer write enable
pe_mem_sel  out  1  0 = weight buffer, 1 = data buffer
pe_mem_addrs  out  PE_AW  PE buffer address
pe_mem_data  out  DATA_W  PE buffer write data
pe_start  out  1  one-cycle start pulse to PE
pe_done  in  1  PE done pulse
pe_data_out  in  DATA_W  PE result, valid while pe_done high
res_wr  out  1  one-cycle result write strobe
res_addr  out  RES_AW  result address
res_data  out  DATA_W  result value
job_done  out  1  one-cycle pulse, coincident with res_wr or error
err  out  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset, rst low at a clock edge, applies in any state including mid-burst:
  - state goes to IDLE; w_valid goes to 0.
  - All outputs go to 0, except job_ready, which is 1 the cycle after reset releases.
  - No partial job is resumed.
  - The PE must be reset at the same time by the system.
- States: IDLE, LD_W, LD_D, GAP, START, WAIT, STORE.
- IDLE:
  - On job_valid && job_ready, latch all job_* fields.
  - If job_reuse_w && w_valid, go to LD_D; otherwise go to LD_W.
- LD_W / LD_D burst:
  - Issue src_rd for KERN_LEN consecutive cycles at base+0..base+KERN_LEN-1.
  - Each returned word is written to the PE one cycle later: pe_mem_wr=1, pe_mem_addrs=index, pe_mem_data=src_rdata.
  - pe_mem_sel is 0 in LD_W and 1 in LD_D, and holds constant for the whole burst.
  - pe_mem_wr is high for exactly KERN_LEN contiguous cycles.
  - Each burst lasts KERN_LEN+1 cycles.
  - Between LD_W and LD_D, pe_mem_wr drops for exactly 1 cycle.
  - Source address arithmetic wraps modulo 2**SRC_AW.
- On LD_W completion, set w_valid=1. w_valid clears only on reset.
- GAP: pe_mem_wr=0 for 2 cycles so the PE returns to idle before start.
- START: pe_start=1 for exactly 1 cycle, then go to WAIT. The wait counter clears.
- WAIT:
  - On pe_done, capture pe_data_out and go to STORE.
  - When the counter reaches TIMEOUT with no pe_done: set err, pulse job_done without res_wr, go to IDLE.
  - A pe_done arriving outside WAIT is ignored.
- STORE: res_wr=1, res_addr=latched address, res_data=captured value, job_done=1, each for 1 cycle; then go to IDLE.
- Latency from job accept to job_done, no reuse: 2*(KERN_LEN+1)+1+2+1+PE_latency+1.
- Back-to-back jobs: job_ready returns the cycle after STORE. A job_valid held high is accepted then.
- Job fields change only on accept; changes on job_* while busy have no effect.

Decomposition:
- Shared header: state encodings and a KERN_LEN define from weightM*weightN.
- Widths come from the existing data_width and PE_BUFF_ADDRS_WIDTH defines.
- One natural sub-module, pe_win_loader: the KERN_LEN burst engine (read issue, one-cycle delayed write, index counter, done pulse). It is instantiated once and reused for both bursts via a sel input.

Test Plan:
- Weights 1..9 at src 0x000, data all 2 at 0x100, res_addr 0x20, real procEng attached -> nine weight writes with sel=0, a 1-cycle gap, nine data writes with sel=1, one pe_start; res_wr at 0x20 with res_data 90; job_done 1 cycle.
- Weights 0xFF and data 0xFF -> res_data 0x09 (585225 mod 256, low-byte truncation).
- Second job with job_reuse_w=1 after a completed job -> exactly 9 src_rd cycles, no sel=0 writes; result correct with new data 3s against weights 1..9 = 135.
- pe_done tied low -> err=1 after 64 WAIT cycles; job_done pulses, res_wr stays 0; next job accepted.
- rst low during the 5th cycle of LD_D -> all outputs 0, job_ready=1 after release, w_valid=0 (next reuse job reloads weights).
- Two back-to-back jobs with job_valid held high -> second accepted the cycle after the first STORE; two res_wr strobes at the correct addresses.

Source files
------------

// File: rtl/pe_job_sched_pkg.sv
// pe_job_sched_pkg: shared widths, kernel size and scheduler state encoding
package pe_job_sched_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int PE_BUFF_ADDRS_WIDTH = 4;
  localparam int WEIGHT_M = 3;
  localparam int WEIGHT_N = 3;
  localparam int KERN_LEN_DEF = WEIGHT_M * WEIGHT_N;
  typedef enum logic [2:0] {IDLE, LD_W, LD_D, GAP, START, WAIT, STORE} state_t;
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction
endpackage

// File: rtl/pe_job_sched_win_loader.sv
// pe_win_loader: KERN_LEN-word burst from source BRAM into one PE buffer
module pe_win_loader
  import pe_job_sched_pkg::*;
#(
  parameter int DATA_W   = DATA_WIDTH,
  parameter int PE_AW    = PE_BUFF_ADDRS_WIDTH,
  parameter int KERN_LEN = KERN_LEN_DEF,
  parameter int SRC_AW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              sel,
  input  logic [SRC_AW-1:0] base,
  output logic              src_rd,
  output logic [SRC_AW-1:0] src_addr,
  input  logic [DATA_W-1:0] src_rdata,
  output logic              pe_mem_wr,
  output logic              pe_mem_sel,
  output logic [PE_AW-1:0]  pe_mem_addrs,
  output logic [DATA_W-1:0] pe_mem_data,
  output logic              done
);
  localparam logic [PE_AW-1:0] LAST = PE_AW'(KERN_LEN - 1);
  logic [PE_AW-1:0] idx;
  // issue reads base..base+KERN_LEN-1, write each word to the PE one cycle later
  always_ff @(posedge clk) begin
    if (!rst) begin
      src_rd       <= 1'b0;
      src_addr     <= '0;
      idx          <= '0;
      pe_mem_wr    <= 1'b0;
      pe_mem_sel   <= 1'b0;
      pe_mem_addrs <= '0;
    end else begin
      pe_mem_wr    <= src_rd;
      pe_mem_addrs <= idx;
      if (go) begin
        src_rd     <= 1'b1;
        src_addr   <= base;
        idx        <= '0;
        pe_mem_sel <= sel;
      end else if (src_rd) begin
        src_rd   <= idx != LAST;
        src_addr <= src_addr + 1'b1;
        idx      <= idx + 1'b1;
      end
    end
  end
  assign pe_mem_data = pe_mem_wr ? src_rdata : '0;
  assign done        = pe_mem_wr && pe_mem_addrs == LAST;
endmodule

// File: rtl/pe_job_sched.sv
// pe_job_sched: runs one PE job: load weights/data, start, wait for done, store result
module pe_job_sched
  import pe_job_sched_pkg::*;
#(
  parameter int DATA_W   = DATA_WIDTH,
  parameter int PE_AW    = PE_BUFF_ADDRS_WIDTH,
  parameter int KERN_LEN = KERN_LEN_DEF,
  parameter int SRC_AW   = 16,
  parameter int RES_AW   = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [SRC_AW-1:0] job_w_base,
  input  logic [SRC_AW-1:0] job_d_base,
  input  logic [RES_AW-1:0] job_res_addr,
  input  logic              job_reuse_w,
  output logic              src_rd,
  output logic [SRC_AW-1:0] src_addr,
  input  logic [DATA_W-1:0] src_rdata,
  output logic              pe_mem_wr,
  output logic              pe_mem_sel,
  output logic [PE_AW-1:0]  pe_mem_addrs,
  output logic [DATA_W-1:0] pe_mem_data,
  output logic              pe_start,
  input  logic              pe_done,
  input  logic [DATA_W-1:0] pe_data_out,
  output logic              res_wr,
  output logic [RES_AW-1:0] res_addr,
  output logic [DATA_W-1:0] res_data,
  output logic              job_done,
  output logic              err
);
  localparam int CW = cnt_width(TIMEOUT);
  state_t            state;
  logic              w_valid, accept, skip_w, ld_go, ld_sel, ld_done;
  logic [SRC_AW-1:0] d_base, ld_base;
  logic [RES_AW-1:0] res_q;
  logic [CW-1:0]     cnt;
  assign accept  = state == IDLE && job_valid && job_ready;
  assign skip_w  = job_reuse_w && w_valid;
  assign ld_go   = accept || (state == LD_W && ld_done);
  assign ld_sel  = state == IDLE ? skip_w : 1'b1;
  assign ld_base = state == IDLE ? (skip_w ? job_d_base : job_w_base) : d_base;
  pe_win_loader #(
    .DATA_W(DATA_W), .PE_AW(PE_AW), .KERN_LEN(KERN_LEN), .SRC_AW(SRC_AW)
  ) u_loader (
    .clk(clk), .rst(rst), .go(ld_go), .sel(ld_sel), .base(ld_base),
    .src_rd(src_rd), .src_addr(src_addr), .src_rdata(src_rdata),
    .pe_mem_wr(pe_mem_wr), .pe_mem_sel(pe_mem_sel), .pe_mem_addrs(pe_mem_addrs),
    .pe_mem_data(pe_mem_data), .done(ld_done)
  );
  // job sequencing FSM; cnt times both the GAP and the WAIT timeout
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      w_valid   <= 1'b0;
      job_ready <= 1'b0;
      pe_start  <= 1'b0;
      res_wr    <= 1'b0;
      res_addr  <= '0;
      res_data  <= '0;
      job_done  <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
      d_base    <= '0;
      res_q     <= '0;
    end else begin
      pe_start <= 1'b0;
      res_wr   <= 1'b0;
      job_done <= 1'b0;
      case (state)
        IDLE: begin
          job_ready <= !accept;
          if (accept) begin
            d_base <= job_d_base;
            res_q  <= job_res_addr;
            state  <= skip_w ? LD_D : LD_W;
          end
        end
        LD_W: if (ld_done) begin
          w_valid <= 1'b1;
          state   <= LD_D;
        end
        LD_D: if (ld_done) begin
          cnt   <= '0;
          state <= GAP;
        end
        GAP: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(1)) begin
            pe_start <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (pe_done) begin
            res_wr   <= 1'b1;
            res_addr <= res_q;
            res_data <= pe_data_out;
            job_done <= 1'b1;
            state    <= STORE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            err       <= 1'b1;
            job_done  <= 1'b1;
            job_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STORE: begin
          res_addr  <= '0;
          res_data  <= '0;
          job_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_job_sched.sv
// tb_pe_job_sched: scoreboard bench with source memory and behavioural PE models
module tb_pe_job_sched;
  localparam int K = 9;
  localparam int TO = 64;
  typedef struct {
    logic        to;
    logic        err;
    logic [15:0] addr;
    logic [7:0]  data;
    int          n_rd;
    int          n_w0;
    int          lat;
  } exp_t;
  logic clk = 1'b0, rst = 1'b0;
  logic job_valid = 1'b0, job_ready, job_reuse_w = 1'b0;
  logic [15:0] job_w_base = '0, job_d_base = '0, job_res_addr = '0;
  logic src_rd, pe_mem_wr, pe_mem_sel, pe_start, pe_done, res_wr, job_done, err;
  logic [15:0] src_addr, res_addr;
  logic [7:0] src_rdata = '0, pe_mem_data, pe_data_out = '0, res_data;
  logic [3:0] pe_mem_addrs;
  logic [7:0] src_mem [0:65535];
  logic [7:0] wbuf [0:15];
  logic [7:0] dbuf [0:15];
  logic [7:0] m_w [0:K-1];
  logic [7:0] pe_acc = '0;
  logic pe_done_m = 1'b0, stray = 1'b0, pe_dead = 1'b0, m_wv = 1'b0, m_err = 1'b0;
  int pe_cnt = 0, pe_lat = 3, cyc = 0, acc_cyc = 0, n_rd = 0, n_w0 = 0;
  int n_cmp = 0, n_fail = 0;
  exp_t sbq[$];
  assign pe_done = pe_done_m | stray;
  pe_job_sched dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_w_base(job_w_base), .job_d_base(job_d_base), .job_res_addr(job_res_addr),
    .job_reuse_w(job_reuse_w), .src_rd(src_rd), .src_addr(src_addr), .src_rdata(src_rdata),
    .pe_mem_wr(pe_mem_wr), .pe_mem_sel(pe_mem_sel), .pe_mem_addrs(pe_mem_addrs),
    .pe_mem_data(pe_mem_data), .pe_start(pe_start), .pe_done(pe_done),
    .pe_data_out(pe_data_out), .res_wr(res_wr), .res_addr(res_addr), .res_data(res_data),
    .job_done(job_done), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (src_rd) src_rdata <= src_mem[src_addr];
  function automatic logic [7:0] dot();
    int s = 0;
    for (int i = 0; i < K; i++) s += int'(wbuf[i]) * int'(dbuf[i]);
    return 8'(s);
  endfunction
  always @(posedge clk) begin
    pe_done_m   <= 1'b0;
    pe_data_out <= '0;
    if (!rst) pe_cnt <= 0;
    else begin
      if (pe_mem_wr && pe_mem_sel) dbuf[pe_mem_addrs] <= pe_mem_data;
      if (pe_mem_wr && !pe_mem_sel) wbuf[pe_mem_addrs] <= pe_mem_data;
      if (pe_start) begin
        pe_cnt <= pe_lat;
        pe_acc <= dot();
      end else if (pe_cnt != 0) begin
        pe_cnt <= pe_cnt - 1;
        if (pe_cnt == 1 && !pe_dead) begin
          pe_done_m   <= 1'b1;
          pe_data_out <= pe_acc;
        end
      end
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(posedge clk) if (rst && job_valid && job_ready) acc_cyc <= cyc;
  always @(negedge clk) begin
    if (!rst) begin
      n_rd = 0;
      n_w0 = 0;
    end else begin
      if (src_rd) n_rd++;
      if (pe_mem_wr && !pe_mem_sel) n_w0++;
      if (res_wr && !job_done) chk("res_wr_without_done", 1, 0);
      if (job_done) begin
        if (sbq.size() == 0) chk("unexpected_job_done", 1, 0);
        else begin
          exp_t e;
          e = sbq.pop_front();
          chk("res_wr", int'(res_wr), int'(!e.to));
          chk("err", int'(err), int'(e.err));
          if (!e.to) begin
            chk("res_addr", int'(res_addr), int'(e.addr));
            chk("res_data", int'(res_data), int'(e.data));
          end
          chk("src_rd_count", n_rd, e.n_rd);
          chk("weight_write_count", n_w0, e.n_w0);
          chk("latency", cyc - acc_cyc, e.lat);
        end
        n_rd = 0;
        n_w0 = 0;
      end
    end
  end
  task automatic fill(input logic [15:0] base, input int mode, input logic [7:0] v);
    logic [15:0] a;
    for (int i = 0; i < K; i++) begin
      a = base + 16'(i);
      src_mem[a] = mode == 0 ? v : mode == 1 ? 8'(i + 1) : 8'($urandom);
    end
  endtask
  task automatic issue(input logic [15:0] wb, db, ra, input logic reuse, input logic dead,
                       input logic hold);
    exp_t e;
    int t = 0, s = 0;
    logic [15:0] a;
    logic wu;
    job_w_base = wb;
    job_d_base = db;
    job_res_addr = ra;
    job_reuse_w = reuse;
    job_valid = 1'b1;
    while (!job_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!job_ready) begin
      chk("job_accept_timeout", 0, 1);
      job_valid = 1'b0;
      return;
    end
    pe_dead = dead;
    wu = reuse && m_wv;
    if (!wu) for (int i = 0; i < K; i++) begin
      a = wb + 16'(i);
      m_w[i] = src_mem[a];
    end
    m_wv = 1'b1;
    for (int i = 0; i < K; i++) begin
      a = db + 16'(i);
      s += int'(m_w[i]) * int'(src_mem[a]);
    end
    m_err = m_err | dead;
    e.to = dead;
    e.err = m_err;
    e.addr = ra;
    e.data = 8'(s);
    e.n_rd = wu ? K : 2 * K;
    e.n_w0 = wu ? 0 : K;
    e.lat = (wu ? 1 : 2) * (K + 1) + 1 + 2 + 1 + (dead ? TO : pe_lat + 1);
    sbq.push_back(e);
    @(negedge clk);
    if (!hold) job_valid = 1'b0;
  endtask
  task automatic wait_done();
    int t = 0;
    while (sbq.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (sbq.size() != 0) begin
      chk("job_done_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask
  task automatic chk_reset_outs(input string n);
    chk({n, "_outs"}, int'(|{src_rd, src_addr, pe_mem_wr, pe_mem_sel, pe_mem_addrs, pe_mem_data,
                             pe_start, res_wr, res_addr, res_data, job_done, err}), 0);
    chk({n, "_job_ready"}, int'(job_ready), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [15:0] wb, db, ra;
    logic ru;
    int t;
    for (int i = 0; i < 65536; i++) src_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", int'(job_ready), 1);
    fill(16'h0000, 1, 8'h00);
    fill(16'h0100, 0, 8'h02);
    issue(16'h0000, 16'h0100, 16'h0020, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    wait_done();
    fill(16'h0400, 0, 8'h03);
    pe_lat = 5;
    issue(16'h0000, 16'h0400, 16'h0021, 1'b1, 1'b0, 1'b0);
    wait_done();
    issue(16'h0000, 16'h0100, 16'h0022, 1'b0, 1'b1, 1'b0);
    wait_done();
    fill(16'h0200, 0, 8'hFF);
    fill(16'h0300, 0, 8'hFF);
    pe_lat = 2;
    issue(16'h0200, 16'h0300, 16'h0023, 1'b0, 1'b0, 1'b0);
    wait_done();
    issue(16'h0000, 16'h0100, 16'h0050, 1'b0, 1'b0, 1'b0);
    t = 0;
    while (!(src_rd && pe_mem_sel) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("reached_ld_d", int'(src_rd && pe_mem_sel), 1);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    m_wv = 1'b0;
    m_err = 1'b0;
    @(negedge clk);
    chk_reset_outs("midburst_reset");
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_midburst_reset", int'(job_ready), 1);
    issue(16'h0000, 16'h0400, 16'h0051, 1'b1, 1'b0, 1'b0);
    wait_done();
    pe_lat = 4;
    issue(16'h0000, 16'h0100, 16'h0060, 1'b0, 1'b0, 1'b1);
    issue(16'h0200, 16'h0400, 16'h0061, 1'b0, 1'b0, 1'b0);
    wait_done();
    for (int j = 0; j < 8; j++) begin
      wb = j == 2 ? 16'hFFFB : 16'($urandom);
      db = j == 5 ? 16'hFFFE : 16'($urandom);
      ra = 16'($urandom);
      ru = 1'($urandom_range(0, 1));
      pe_lat = $urandom_range(1, 8);
      fill(wb, 2, 8'h00);
      fill(db, 2, 8'h00);
      issue(wb, db, ra, ru, 1'b0, 1'b0);
      wait_done();
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
